ck_peak_search: RTL and testbench
=================================

# ck_peak_search

Correlation peak search stage directly downstream of the correlation-score block. It consumes one signed 8-bit match-minus-mismatch score per valid cycle across a programmed number of lags. It tracks the best score and the lag index where that score occurred, then reports the result with a one-cycle done pulse and a threshold-hit flag. The sequence controller starts a search, and it reads the result once done is asserted.

## Interface
Parameters:
- LAG_WIDTH, 8, width of the lag counter, num_lags and best_lag; supports up to 2^LAG_WIDTH-1 lags.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a search; sampled only in IDLE.
- num_lags  input  LAG_WIDTH  number of scores to consume; sampled on the accepted start.
- threshold  input  8  signed detection threshold; sampled on the accepted start.
- score  input  8  signed two's-complement correlation score.
- score_valid  input  1  score is valid this cycle.
- busy  output  1  high in SEARCH and DONE.
- done  output  1  one-cycle pulse when the result is final.
- best_score  output  8  signed best score seen so far.
- best_lag  output  LAG_WIDTH  index (0-based, counted over accepted scores) of best_score.
- found  output  1  best_score >= threshold (signed); valid from done onward.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE:
  - On start, latch num_lags and threshold.
  - Clear lag_cnt to 0, set best_score to -128 (0x80) and best_lag to 0, clear found.
  - If the latched num_lags = 0, go to DONE; otherwise go to SEARCH.
- SEARCH, on each cycle with score_valid:
  - If score > best_score (signed, strict), load best_score <= score and best_lag <= lag_cnt. On ties the first occurrence wins.
  - Increment lag_cnt.
  - If lag_cnt = num_lags-1, go to DONE.
  - Cycles with score_valid low change nothing.
- DONE:
  - done = 1 for exactly this cycle.
  - found <= (best_score >= threshold) on entry to DONE, computed from the final best value.
  - Return to IDLE next cycle.
- Results (best_score, best_lag, found) hold in IDLE until the next accepted start.
- In DONE, start is ignored and score_valid is ignored.
- In SEARCH, start is ignored.
- Arithmetic: all comparisons are signed 8-bit. lag_cnt is LAG_WIDTH bits and never wraps, because the search ends at num_lags-1.
- Reset values: state IDLE, busy 0, done 0, best_score 0x00, best_lag 0, found 0, lag_cnt 0.
- rst mid-search: abandon the search immediately and apply the reset values; no done pulse.

## Timing
- start accepted at edge N: busy = 1 from cycle N+1.
- The last valid score is sampled at edge M. best_score and best_lag are final, done = 1 and found are valid in cycle M+1, and busy falls at edge M+2.
- Minimum search length: num_lags + 1 cycles after start when score_valid is held high.
- num_lags = 0: done in cycle N+1 with best_score = 0x80, best_lag = 0, found = (threshold == -128).
- A new start is accepted in the first IDLE cycle after DONE, giving back-to-back searches with one idle cycle between them.

## Configuration
- Macro: CK_PEAK_ABS_EN.
- Defined:
  - The comparison uses the magnitude mag(score), so strong anti-correlation counts as a peak.
  - mag(-128) saturates to 127.
  - best_score stores the magnitude, which is always >= 0.
  - The search initial value is 0x00 instead of 0x80.
  - The num_lags = 0 result is best_score = 0.
- Undefined: plain signed compare as described above.

## Structure
- Package ck_search_pkg holds:
  - SCORE_WIDTH = 8
  - SCORE_MIN = 8'sh80
  - the state encoding (IDLE = 0, SEARCH = 1, DONE = 2, 2-bit)
- Sub-module ck_score_cmp is combinational. It takes the candidate score and best_score, applies the optional magnitude/saturation, and outputs the update flag and the value to store. It is the only place where CK_PEAK_ABS_EN is tested.

## Test plan
- num_lags = 4, threshold = 2, scores 1, 5, 3, 5 continuously valid -> done one cycle after the 4th score; best_score = 5, best_lag = 1 (tie keeps first), found = 1.
- num_lags = 3, threshold = 0, scores -3, -7, -1 -> best_score = -1, best_lag = 2, found = 0. With CK_PEAK_ABS_EN defined -> best_score = 7, best_lag = 1, found = 1.
- num_lags = 3 with score_valid gaps (valid pattern 1,0,0,1,0,1), scores 2, x, x, 6, x, 4 -> best_lag = 1, best_score = 6, done 1 cycle after the 6th cycle.
- num_lags = 0, threshold = -128 -> done in the cycle after start, best_score = 0x80, found = 1.
- rst asserted after 2 of 8 scores -> all outputs return to reset values, no done pulse; start is accepted the cycle after rst deasserts.
- start pulsed during SEARCH and during DONE -> ignored. An immediate new start in the following IDLE cycle runs a fresh search with best_score reinitialised.

Source files
------------

// File: rtl/ck_peak_search_pkg.sv
// Shared types and constants for the correlation peak search stage.
// The optional magnitude-compare feature is selected with CK_PEAK_ABS_EN
// (tested only inside ck_score_cmp).
package ck_search_pkg;

    localparam int unsigned SCORE_WIDTH = 8;
    localparam logic signed [SCORE_WIDTH-1:0] SCORE_MIN = 8'sh80;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } state_e;

endpackage

// File: rtl/ck_peak_search_if.sv
// Control, score stream and result signals of the peak search stage.
// master: sequence controller / score source side. slave: the search block.
interface ck_peak_search_if #(
    parameter int unsigned LAG_WIDTH = 8
);
    import ck_search_pkg::*;

    logic                          start;
    logic [LAG_WIDTH-1:0]          num_lags;
    logic signed [SCORE_WIDTH-1:0] threshold;
    logic signed [SCORE_WIDTH-1:0] score;
    logic                          score_valid;
    logic                          busy;
    logic                          done;
    logic signed [SCORE_WIDTH-1:0] best_score;
    logic [LAG_WIDTH-1:0]          best_lag;
    logic                          found;

    modport master (
        output start, num_lags, threshold, score, score_valid,
        input  busy, done, best_score, best_lag, found
    );

    modport slave (
        input  start, num_lags, threshold, score, score_valid,
        output busy, done, best_score, best_lag, found
    );

endinterface

// File: rtl/ck_peak_search_score_cmp.sv
// Combinational candidate-vs-best comparator for the peak search.
// With CK_PEAK_ABS_EN defined the candidate is replaced by its saturated
// magnitude and the search starts from zero; otherwise a plain signed compare
// starting from the most negative score.
module ck_score_cmp
    import ck_search_pkg::*;
(
    input  logic signed [SCORE_WIDTH-1:0] score_i,
    input  logic signed [SCORE_WIDTH-1:0] best_i,
    output logic                          update_o,
    output logic signed [SCORE_WIDTH-1:0] value_o,
    output logic signed [SCORE_WIDTH-1:0] init_o
);

`ifdef CK_PEAK_ABS_EN
    // Saturated magnitude: -128 has no positive counterpart, clamp to 127.
    always_comb begin
        value_o = score_i;
        if (score_i == SCORE_MIN) begin
            value_o = 8'sd127;
        end else if (score_i[SCORE_WIDTH-1]) begin
            value_o = -score_i;
        end
        update_o = value_o > best_i;
        init_o   = '0;
    end
`else
    // Plain signed compare; strict so the first occurrence of a tie wins.
    always_comb begin
        value_o  = score_i;
        update_o = score_i > best_i;
        init_o   = SCORE_MIN;
    end
`endif

endmodule

// File: rtl/ck_peak_search.sv
// Correlation peak search: tracks the best score and its lag over a
// programmed number of valid scores, then pulses done with a threshold flag.
// Build option CK_PEAK_ABS_EN switches to a magnitude search (see ck_score_cmp).
module ck_peak_search
    import ck_search_pkg::*;
#(
    parameter int unsigned LAG_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    ck_peak_search_if.slave bus
);

    state_e                        state_q, state_d;
    logic [LAG_WIDTH-1:0]          num_lags_q, num_lags_d;
    logic signed [SCORE_WIDTH-1:0] threshold_q, threshold_d;
    logic [LAG_WIDTH-1:0]          lag_cnt_q, lag_cnt_d;
    logic signed [SCORE_WIDTH-1:0] best_score_q, best_score_d;
    logic [LAG_WIDTH-1:0]          best_lag_q, best_lag_d;
    logic                          found_q, found_d;

    logic                          cmp_update;
    logic signed [SCORE_WIDTH-1:0] cmp_value;
    logic signed [SCORE_WIDTH-1:0] cmp_init;

    ck_score_cmp u_cmp (
        .score_i  (bus.score),
        .best_i   (best_score_q),
        .update_o (cmp_update),
        .value_o  (cmp_value),
        .init_o   (cmp_init)
    );

    // Next-state: start acceptance, per-score update and result capture.
    always_comb begin
        state_d      = state_q;
        num_lags_d   = num_lags_q;
        threshold_d  = threshold_q;
        lag_cnt_d    = lag_cnt_q;
        best_score_d = best_score_q;
        best_lag_d   = best_lag_q;
        found_d      = found_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    num_lags_d   = bus.num_lags;
                    threshold_d  = bus.threshold;
                    lag_cnt_d    = '0;
                    best_score_d = cmp_init;
                    best_lag_d   = '0;
                    found_d      = 1'b0;
                    if (bus.num_lags == '0) begin
                        // Empty search: result is the initial value.
                        state_d = StDone;
                        found_d = cmp_init >= bus.threshold;
                    end else begin
                        state_d = StSearch;
                    end
                end
            end
            StSearch: begin
                if (bus.score_valid) begin
                    if (cmp_update) begin
                        best_score_d = cmp_value;
                        best_lag_d   = lag_cnt_q;
                    end
                    lag_cnt_d = lag_cnt_q + LAG_WIDTH'(1);
                    if (lag_cnt_q == num_lags_q - LAG_WIDTH'(1)) begin
                        // Flag uses the best value including this last score.
                        state_d = StDone;
                        found_d = best_score_d >= threshold_q;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            num_lags_q   <= '0;
            threshold_q  <= '0;
            lag_cnt_q    <= '0;
            best_score_q <= '0;
            best_lag_q   <= '0;
            found_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_lags_q   <= num_lags_d;
            threshold_q  <= threshold_d;
            lag_cnt_q    <= lag_cnt_d;
            best_score_q <= best_score_d;
            best_lag_q   <= best_lag_d;
            found_q      <= found_d;
        end
    end

    // Status and result outputs straight from registered state.
    always_comb begin
        bus.busy       = state_q != StIdle;
        bus.done       = state_q == StDone;
        bus.best_score = best_score_q;
        bus.best_lag   = best_lag_q;
        bus.found      = found_q;
    end

endmodule

// File: tb/tb_ck_peak_search.sv
// Self-checking bench for ck_peak_search: directed cases followed by random
// searches, each checked against a max/first-index reference model.
module tb_ck_peak_search;
    import ck_search_pkg::*;

    localparam int unsigned LW = 8;

    logic clk = 1'b0;
    logic rst;

    ck_peak_search_if #(.LAG_WIDTH(LW)) bus ();

    ck_peak_search #(.LAG_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic signed [7:0] stim_score[$];
    logic              stim_valid[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value a score contributes to the search.
    function automatic int peak_val(input logic signed [7:0] s);
        int v;
        v = int'(s);
`ifdef CK_PEAK_ABS_EN
        if (v < 0) v = -v;
        if (v > 127) v = 127;
`endif
        return v;
    endfunction

    // Reference: maximum of the start value and all accepted scores, lag is the
    // first index reaching that maximum.
    task automatic model(input logic signed [7:0] acc[$], input logic signed [7:0] thr,
                         output logic [7:0] eb, output logic [7:0] el, output logic ef);
        int best;
`ifdef CK_PEAK_ABS_EN
        best = 0;
`else
        best = -128;
`endif
        foreach (acc[i]) if (peak_val(acc[i]) > best) best = peak_val(acc[i]);
        el = '0;
        for (int i = 0; i < acc.size(); i++) begin
            if (peak_val(acc[i]) == best) begin
                el = 8'(i);
                break;
            end
        end
        eb = 8'(best);
        ef = best >= int'(thr);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE
    // cycle after DONE so a following call starts back-to-back.
    task automatic run_search(input string name, input int n, input logic signed [7:0] thr);
        logic signed [7:0] acc[$];
        logic [7:0]        eb, el;
        logic              ef, v;
        logic signed [7:0] s;
        int                idx, got;
        idx = 0;
        got = 0;
        bus.start       = 1'b1;
        bus.num_lags    = LW'(n);
        bus.threshold   = thr;
        bus.score_valid = 1'b0;
        bus.score       = 8'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, ".busy_start"}, 8'(bus.busy), 8'd1);
        while (got < n) begin
            chk({name, ".no_early_done"}, 8'(bus.done), 8'd0);
            v = (idx < stim_valid.size()) ? stim_valid[idx] : 1'b1;
            s = (idx < stim_score.size()) ? stim_score[idx] : 8'($urandom);
            bus.score_valid = v;
            bus.score       = s;
            // Start and new config during the search must be ignored.
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.num_lags  = LW'($urandom);
            bus.threshold = 8'($urandom);
            if (v) begin
                acc.push_back(s);
                got++;
            end
            idx++;
            @(negedge clk);
        end
        model(acc, thr, eb, el, ef);
        chk({name, ".done"}, 8'(bus.done), 8'd1);
        chk({name, ".busy_done"}, 8'(bus.busy), 8'd1);
        chk({name, ".best_score"}, bus.best_score, eb);
        chk({name, ".best_lag"}, bus.best_lag, el);
        chk({name, ".found"}, 8'(bus.found), 8'(ef));
        // Stimulus in DONE must be ignored.
        bus.start       = 1'b1;
        bus.score_valid = 1'b1;
        bus.score       = 8'sd127;
        bus.num_lags    = LW'($urandom);
        @(negedge clk);
        bus.start       = 1'b0;
        bus.score_valid = 1'b0;
        chk({name, ".done_pulse"}, 8'(bus.done), 8'd0);
        chk({name, ".busy_idle"}, 8'(bus.busy), 8'd0);
        chk({name, ".hold_score"}, bus.best_score, eb);
        chk({name, ".hold_lag"}, bus.best_lag, el);
        chk({name, ".hold_found"}, 8'(bus.found), 8'(ef));
        stim_score.delete();
        stim_valid.delete();
    endtask

    task automatic push(input logic v, input logic signed [7:0] s);
        stim_valid.push_back(v);
        stim_score.push_back(s);
    endtask

    initial begin
        int n;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.num_lags    = '0;
        bus.threshold   = '0;
        bus.score       = '0;
        bus.score_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 8'(bus.busy), 8'd0);
        chk("rst.done", 8'(bus.done), 8'd0);
        chk("rst.best_score", bus.best_score, 8'h00);
        chk("rst.best_lag", bus.best_lag, 8'h00);
        chk("rst.found", 8'(bus.found), 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Tie keeps the first occurrence.
        push(1, 8'sd1); push(1, 8'sd5); push(1, 8'sd3); push(1, 8'sd5);
        run_search("tp1", 4, 8'sd2);
        chk("tp1.const_score", bus.best_score, 8'd5);
        chk("tp1.const_lag", bus.best_lag, 8'd1);
        chk("tp1.const_found", 8'(bus.found), 8'd1);

        // All-negative scores, back-to-back with the previous search.
        push(1, -8'sd3); push(1, -8'sd7); push(1, -8'sd1);
        run_search("tp2", 3, 8'sd0);
`ifdef CK_PEAK_ABS_EN
        chk("tp2.const_score", bus.best_score, 8'd7);
        chk("tp2.const_lag", bus.best_lag, 8'd1);
        chk("tp2.const_found", 8'(bus.found), 8'd1);
`else
        chk("tp2.const_score", bus.best_score, 8'hff);
        chk("tp2.const_lag", bus.best_lag, 8'd2);
        chk("tp2.const_found", 8'(bus.found), 8'd0);
`endif

        // Valid gaps: only accepted scores advance the lag.
        @(negedge clk);
        push(1, 8'sd2); push(0, 8'sd99); push(0, -8'sd50);
        push(1, 8'sd6); push(0, 8'sd100); push(1, 8'sd4);
        run_search("tp3", 3, 8'sd10);
        chk("tp3.const_score", bus.best_score, 8'd6);
        chk("tp3.const_lag", bus.best_lag, 8'd1);

        // Empty search.
        run_search("tp4", 0, -8'sd128);
`ifdef CK_PEAK_ABS_EN
        chk("tp4.const_score", bus.best_score, 8'h00);
`else
        chk("tp4.const_score", bus.best_score, 8'h80);
`endif
        chk("tp4.const_found", 8'(bus.found), 8'd1);

        // Reset two scores into an 8-score search.
        bus.start     = 1'b1;
        bus.num_lags  = LW'(8);
        bus.threshold = -8'sd100;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.score_valid = 1'b1;
        bus.score       = 8'sd90;
        @(negedge clk);
        bus.score = 8'sd40;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.busy", 8'(bus.busy), 8'd0);
        chk("rstmid.done", 8'(bus.done), 8'd0);
        chk("rstmid.best_score", bus.best_score, 8'h00);
        chk("rstmid.best_lag", bus.best_lag, 8'h00);
        chk("rstmid.found", 8'(bus.found), 8'd0);
        rst             = 1'b0;
        bus.score_valid = 1'b0;
        // Start in the first cycle after reset; best must not keep 90.
        push(1, -8'sd50); push(1, -8'sd20);
        run_search("postrst", 2, -8'sd30);

        // Random searches, some back-to-back, some with idle gaps.
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(1, 12);
            for (int k = 0; k < 3 * n; k++) begin
                case ($urandom_range(0, 5))
                    0:       push($urandom_range(0, 2) != 0, -8'sd128);
                    1:       push($urandom_range(0, 2) != 0, 8'sd127);
                    default: push($urandom_range(0, 2) != 0, 8'($urandom));
                endcase
            end
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_search($sformatf("rnd%0d", t), n, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
